// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: 6x6 unsigned shift-add multiplier that uses an external
// 6-bit ALU as its adder. A right-shifting product/multiplier register holds
// the partial product in P[11:6] and the unused multiplier bits in P[5:0].
// Each CALC cycle either adds M into the upper half through the ALU and
// shifts, or only shifts. Six iterations produce the 12-bit product.
// Handshake: start is accepted only in IDLE, busy covers CALC and DONE, and
// done pulses for the single DONE cycle.
module alu_seq_multiplier #(
    parameter int          WIDTH   = 6,
    parameter logic [3:0]  OP_ADD  = 4'b0010,
    parameter logic [3:0]  OP_IDLE = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_cin,
    output logic [3:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index of the final add/shift iteration.
    localparam logic [2:0] LAST_ITER = 3'(WIDTH - 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [2*WIDTH-1:0]    p_q, p_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    // Value of the product register after the current iteration. When the
    // multiplier LSB is 1 the ALU sum (with its carry) replaces the upper
    // half; otherwise the upper half is shifted down unchanged.
    logic [2*WIDTH-1:0]    p_shift;

    // Next-state logic: operand capture, one iteration per CALC cycle, and
    // product latch on the final iteration.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        p_shift   = p_q[0] ? {alu_cout, alu_result, p_q[WIDTH-1:1]}
                           : {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    cnt_d   = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d   = p_shift;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    product_d = p_shift;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Start is ignored here; the next request is taken in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any
    // computation in flight without a done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // ALU drive and handshake outputs, decoded from registered state only.
    always_comb begin
        alu_a   = p_q[2*WIDTH-1:WIDTH];
        alu_b   = m_q;
        alu_cin = 1'b0;
        alu_op  = (state_q == CALC) ? OP_ADD : OP_IDLE;
        busy    = (state_q == CALC) || (state_q == DONE);
        done    = (state_q == DONE);
        product = product_q;
    end

endmodule
